// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port ASIP register file.
// DATA_W and register count defaults live here so the datapath and hazard unit agree.
package regfile_pkg;

    localparam int RF_DATA_W      = 17;
    localparam int RF_NREGS       = 16;
    localparam int RF_AW          = $clog2(RF_NREGS);
    localparam int PC_IDX_DEFAULT = RF_NREGS - 1;

    typedef logic [RF_AW-1:0]     reg_addr_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

    // True when an address names a register that physically exists.
    function automatic logic in_range(input logic [31:0] idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the register file: read ports, write ports, pc and issue/scoreboard signals.
// The master side is the datapath/hazard unit, the slave side is the register file.
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int NWR    = 1
);

    logic [NRD*AW-1:0]     ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rbusy;
    logic [NWR-1:0]        we;
    logic [NWR*AW-1:0]     wa;
    logic [NWR*DATA_W-1:0] wd;
    logic [DATA_W-1:0]     pc;
    logic                  iss_v;
    logic [AW-1:0]         iss_a;
    logic [NREGS-1:0]      busy_vec;

    modport master (
        output ra, we, wa, wd, pc, iss_v, iss_a,
        input  rd, rbusy, busy_vec
    );

    modport slave (
        input  ra, we, wa, wd, pc, iss_v, iss_a,
        output rd, rbusy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending writebacks, with issue-over-writeback priority.
// Also answers the busy lookup for every read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = RF_NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int PC_IDX = NREGS - 1,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] ra,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    output logic [NRD-1:0]    rbusy,
    output logic [NREGS-1:0]  busy_vec
);

    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first, then the issue set, so a new producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && in_range(32'(wa[j*AW +: AW]), NREGS)) begin
                busy_d[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_v && iss_a != PC_A && in_range(32'(iss_a), NREGS)) begin
            busy_d[iss_a] = 1'b1;
        end
        busy_d[PC_IDX] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rbusy
        logic [AW-1:0] a;
        logic          hit;
        logic          rb;

        assign a = ra[i*AW +: AW];

        always_comb begin
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && wa[j*AW +: AW] == a) begin
                    hit = 1'b1;
                end
            end
        end

        // A bypassed read already has its data; only a same-cycle reissue keeps it busy.
        always_comb begin
            rb = 1'b0;
            if (a == PC_A || !in_range(32'(a), NREGS)) begin
                rb = 1'b0;
            end else if (BYPASS != 0 && hit) begin
                rb = iss_v && (iss_a == a);
            end else begin
                rb = busy_q[a];
            end
        end

        assign rbusy[i] = rb;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with PC injection, optional write-to-read bypass and a busy scoreboard.
// Storage, bypass and the PC mux live here; busy tracking is in regfile_scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int PC_IDX = NREGS - 1,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_sb_if.slave bus
);

    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic [DATA_W-1:0] rf_q [NREGS];

    // Ports are applied in ascending order so the highest-numbered port wins a conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                rf_q[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && bus.wa[j*AW +: AW] != PC_A &&
                    in_range(32'(bus.wa[j*AW +: AW]), NREGS)) begin
                    rf_q[bus.wa[j*AW +: AW]] <= bus.wd[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_read
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] v;

        assign a = bus.ra[i*AW +: AW];

        always_comb begin
            v = '0;
            if (in_range(32'(a), NREGS)) begin
                v = rf_q[a];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (bus.we[j] && bus.wa[j*AW +: AW] == a) begin
                            v = bus.wd[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            if (a == PC_A) begin
                v = bus.pc;
            end
        end

        assign bus.rd[i*DATA_W +: DATA_W] = v;
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NRD    (NRD),
        .NWR    (NWR),
        .PC_IDX (PC_IDX),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .ra       (bus.ra),
        .we       (bus.we),
        .wa       (bus.wa),
        .iss_v    (bus.iss_v),
        .iss_a    (bus.iss_a),
        .rbusy    (bus.rbusy),
        .busy_vec (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: one bypassing and one non-bypassing instance share stimulus.
// Expected outputs come from an array model of registers and busy bits.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int DW  = RF_DATA_W;
    localparam int NR  = RF_NREGS;
    localparam int AW  = $clog2(NR);
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int PCI = PC_IDX_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus1 ();
    regfile_mp_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus0 ();

    regfile_mp_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .PC_IDX(PCI), .BYPASS(1))
        dut1 (.clk(clk), .reset(rst), .bus(bus1.slave));
    regfile_mp_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .PC_IDX(PCI), .BYPASS(0))
        dut0 (.clk(clk), .reset(rst), .bus(bus0.slave));

    // Current stimulus
    logic [AW-1:0]  s_ra [NRD];
    logic [NWR-1:0] s_we;
    logic [AW-1:0]  s_wa [NWR];
    logic [DW-1:0]  s_wd [NWR];
    logic [DW-1:0]  s_pc;
    logic           s_iv;
    logic [AW-1:0]  s_ia;

    // Reference model
    logic [DW-1:0] m_rf [NR];
    bit            m_busy [NR];

    typedef struct {
        logic [NRD*DW-1:0] rd1;
        logic [NRD*DW-1:0] rd0;
        logic [NRD-1:0]    rb1;
        logic [NRD-1:0]    rb0;
        logic [NR-1:0]     bv;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a, input bit byp);
        logic [DW-1:0] v;
        if (a == PCI) return s_pc;
        v = m_rf[a];
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (s_we[j] && int'(s_wa[j]) == a) v = s_wd[j];
        return v;
    endfunction

    function automatic bit m_rbusy(input int a, input bit byp);
        bit hit;
        hit = 1'b0;
        if (a == PCI) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (s_we[j] && int'(s_wa[j]) == a) hit = 1'b1;
        if (byp && hit) return s_iv && int'(s_ia) == a;
        return m_busy[a];
    endfunction

    task automatic apply();
        bus1.ra = {s_ra[1], s_ra[0]};   bus0.ra = {s_ra[1], s_ra[0]};
        bus1.we = s_we;                 bus0.we = s_we;
        bus1.wa = {s_wa[1], s_wa[0]};   bus0.wa = {s_wa[1], s_wa[0]};
        bus1.wd = {s_wd[1], s_wd[0]};   bus0.wd = {s_wd[1], s_wd[0]};
        bus1.pc = s_pc;                 bus0.pc = s_pc;
        bus1.iss_v = s_iv;              bus0.iss_v = s_iv;
        bus1.iss_a = s_ia;              bus0.iss_a = s_ia;
    endtask

    task automatic idle();
        s_we = '0;
        s_iv = 1'b0;
    endtask

    // Drive this cycle's inputs and queue what the outputs must show before the next edge.
    task automatic drive_now();
        exp_t e;
        apply();
        for (int i = 0; i < NRD; i++) begin
            e.rd1[i*DW +: DW] = m_read(int'(s_ra[i]), 1'b1);
            e.rd0[i*DW +: DW] = m_read(int'(s_ra[i]), 1'b0);
            e.rb1[i]          = m_rbusy(int'(s_ra[i]), 1'b1);
            e.rb0[i]          = m_rbusy(int'(s_ra[i]), 1'b0);
        end
        for (int r = 0; r < NR; r++) e.bv[r] = m_busy[r];
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int j = 0; j < NWR; j++)
            if (s_we[j] && int'(s_wa[j]) != PCI) m_rf[s_wa[j]] = s_wd[j];
        for (int j = 0; j < NWR; j++)
            if (s_we[j]) m_busy[s_wa[j]] = 1'b0;
        if (s_iv && int'(s_ia) != PCI) m_busy[s_ia] = 1'b1;
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_rf[r]   = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Monitor: compares both instances against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("rd_byp",    bus1.rd,       mon_e.rd1);
            check("rd_nobyp",  bus0.rd,       mon_e.rd0);
            check("rbusy_byp", bus1.rbusy,    mon_e.rb1);
            check("rbusy_nob", bus0.rbusy,    mon_e.rb0);
            check("busy_byp",  bus1.busy_vec, mon_e.bv);
            check("busy_nob",  bus0.busy_vec, mon_e.bv);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        model_clear();
        for (int i = 0; i < NRD; i++) s_ra[i] = '0;
        for (int j = 0; j < NWR; j++) begin
            s_wa[j] = '0;
            s_wd[j] = '0;
        end
        s_ia = '0;
        s_pc = 17'h00040;
        idle();
        s_ra[0] = 4'd3;
        s_ra[1] = 4'd15;
        apply();
        #2;
        check("rst0_rd",   bus1.rd, {17'h00040, 17'h00000});
        check("rst0_busy", bus1.busy_vec, 16'h0000);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill r0..r14 with 17'h1ABCD; r4 is issued in the same cycle it is written.
        for (int r = 0; r < 15; r += 2) begin
            s_we    = (r + 1 < 15) ? 2'b11 : 2'b01;
            s_wa[0] = AW'(r);
            s_wa[1] = AW'(r + 1);
            s_wd[0] = 17'h1ABCD;
            s_wd[1] = 17'h1ABCD;
            s_ra[0] = AW'(r);
            s_ra[1] = AW'(r + 1);
            s_iv    = (r == 4);
            s_ia    = 4'd4;
            drive_now();
            tick();
        end

        // Async reset pulse between edges
        idle();
        s_ra[0] = 4'd3;
        s_ra[1] = 4'd15;
        s_pc    = 17'h00040;
        apply();
        #1;
        check("pre_rst_rd",   bus1.rd[DW-1:0], 17'h1ABCD);
        check("pre_rst_busy", bus1.busy_vec, 16'h0010);
        rst = 1'b1;
        #1;
        check("rst_rd_byp",   bus1.rd, {17'h00040, 17'h00000});
        check("rst_rd_nobyp", bus0.rd, {17'h00040, 17'h00000});
        check("rst_busy",     bus1.busy_vec, 16'h0000);
        rst = 1'b0;
        model_clear();
        tick();

        // Write then read r3
        s_we = 2'b01; s_wa[0] = 4'd3; s_wd[0] = 17'h12345;
        s_ra[0] = 4'd3; s_ra[1] = 4'd3;
        drive_now();
        #1;
        check("wr_byp",   bus1.rd[DW-1:0], 17'h12345);
        check("wr_nobyp", bus0.rd[DW-1:0], 17'h00000);
        tick();
        idle();
        drive_now();
        #1;
        check("wr_next", bus0.rd[DW-1:0], 17'h12345);
        tick();

        // Two ports hit r5; port 1 wins
        s_we = 2'b11; s_wa[0] = 4'd5; s_wa[1] = 4'd5;
        s_wd[0] = 17'h00011; s_wd[1] = 17'h00022; s_ra[1] = 4'd5;
        drive_now();
        #1;
        check("conf_byp", bus1.rd[2*DW-1:DW], 17'h00022);
        tick();
        idle();
        drive_now();
        #1;
        check("conf_r5", bus0.rd[2*DW-1:DW], 17'h00022);
        tick();

        // PC index: writes and issues dropped, reads track pc
        s_we = 2'b01; s_wa[0] = 4'd15; s_wd[0] = 17'h1FFFF;
        s_ra[0] = 4'd15; s_pc = 17'h0ABCD; s_iv = 1'b1; s_ia = 4'd15;
        drive_now();
        #1;
        check("pc_wr_cycle", bus0.rd[DW-1:0], 17'h0ABCD);
        tick();
        idle();
        s_pc = 17'h00123;
        drive_now();
        #1;
        check("pc_track", bus1.rd[DW-1:0], 17'h00123);
        check("pc_busy",  bus1.busy_vec[15], 1'b0);
        tick();

        // Scoreboard on r7: issue, write-back, then issue+write in one cycle
        s_iv = 1'b1; s_ia = 4'd7; s_ra[0] = 4'd7;
        drive_now(); tick();
        idle();
        drive_now();
        #1;
        check("sb_set", bus1.busy_vec[7], 1'b1);
        tick();
        drive_now(); tick();
        s_we = 2'b01; s_wa[0] = 4'd7; s_wd[0] = 17'h00007;
        drive_now(); tick();
        idle();
        drive_now();
        #1;
        check("sb_clr", bus1.busy_vec[7], 1'b0);
        tick();
        s_iv = 1'b1; s_ia = 4'd7; s_we = 2'b01; s_wa[0] = 4'd7; s_wd[0] = 17'h00070;
        drive_now(); tick();
        idle();
        drive_now();
        #1;
        check("sb_set_wins", bus1.busy_vec[7], 1'b1);
        tick();

        // Bypassed consumer of a busy register
        s_iv = 1'b1; s_ia = 4'd2;
        drive_now(); tick();
        idle();
        s_we = 2'b01; s_wa[0] = 4'd2; s_wd[0] = 17'h00777; s_ra[1] = 4'd2;
        drive_now();
        #1;
        check("byp_rbusy",   bus1.rbusy[1], 1'b0);
        check("byp_rd",      bus1.rd[2*DW-1:DW], 17'h00777);
        check("nobyp_rbusy", bus0.rbusy[1], 1'b1);
        tick();
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NRD; i++) s_ra[i] = AW'($urandom_range(0, NR - 1));
            s_we = NWR'($urandom_range(0, 3));
            for (int j = 0; j < NWR; j++) begin
                s_wa[j] = ($urandom_range(0, 7) == 0) ? AW'(PCI) : AW'($urandom_range(0, 7));
                s_wd[j] = DW'($urandom);
            end
            s_pc = DW'($urandom);
            s_iv = 1'($urandom_range(0, 1));
            s_ia = ($urandom_range(0, 9) == 0) ? AW'(PCI) : AW'($urandom_range(0, 7));
            drive_now();
            tick();
        end

        idle();
        apply();
        check("q_drain", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
